// File: rtl/bus_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package bus_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [15:0] REG_TXDATA = 16'd0;
  localparam logic [15:0] REG_STATUS = 16'd1;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVERRUN = 7;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// 6502-bus mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS reads back state.
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hD000,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        CLOCK_50,
  input  logic        res_n,
  input  logic        phi,
  input  logic [15:0] ab,
  input  logic [7:0]  dbo,
  input  logic        rw,
  output logic        sel,
  output logic [7:0]  dbi,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0] ADDR_TXDATA = BASE_ADDR + REG_TXDATA;
  localparam logic [15:0] ADDR_STATUS = BASE_ADDR + REG_STATUS;

  logic              phi_q;
  logic              bus_strobe;
  logic              hit_data;
  logic              hit_status;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              status_rd;
  logic              overrun;
  logic [7:0]        status_byte;

  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  // phi falling edge as seen in the CLOCK_50 domain; all bus side effects key off it.
  always_ff @(posedge CLOCK_50 or negedge res_n) begin
    if (!res_n) phi_q <= 1'b0;
    else        phi_q <= phi;
  end

  assign bus_strobe = phi_q & ~phi;
  assign hit_data   = (ab == ADDR_TXDATA);
  assign hit_status = (ab == ADDR_STATUS);
  assign sel        = hit_data | hit_status;
  assign push_req   = bus_strobe & hit_data & ~rw;
  assign status_rd  = bus_strobe & hit_status & rw;
  assign pop        = (state_q == IDLE) & ~fifo_empty;
  assign push       = push_req & (~fifo_full | pop);
  assign busy       = (state_q != IDLE) | (fifo_count != '0);

  always_comb begin
    status_byte               = 8'h00;
    status_byte[STAT_BUSY]    = busy;
    status_byte[STAT_FULL]    = fifo_full;
    status_byte[STAT_EMPTY]   = fifo_empty;
    status_byte[STAT_OVERRUN] = overrun;
  end

  assign dbi = (rw & hit_status) ? status_byte : 8'h00;

  // Sticky drop flag; a STATUS read clears it after presenting the old value.
  always_ff @(posedge CLOCK_50 or negedge res_n) begin
    if (!res_n)                                  overrun <= 1'b0;
    else if (status_rd)                          overrun <= 1'b0;
    else if (push_req & fifo_full & ~pop)        overrun <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (res_n),
    .push  (push),
    .pop   (pop),
    .din   (dbo),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serializer state and datapath registers.
  always_ff @(posedge CLOCK_50 or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          shift_d = fifo_dout;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is computed from the next state so the registered pin tracks the FSM with no lag.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed self-checking bench for bus_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_bus_uart_tx;

  logic        CLOCK_50;
  logic        res_n;
  logic        phi;
  logic [15:0] ab;
  logic [7:0]  dbo;
  logic        rw;
  logic        sel;
  logic [7:0]  dbi;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int         mc = 0;
  logic [7:0] msh = 8'h00;
  int         ferr = 0;

  bus_uart_tx #(
    .BASE_ADDR    (16'hD000),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .res_n    (res_n),
    .phi      (phi),
    .ab       (ab),
    .dbo      (dbo),
    .rw       (rw),
    .sel      (sel),
    .dbi      (dbi),
    .tx       (tx),
    .busy     (busy)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Line receiver: samples the middle of each 4-cycle bit, start detected on the first low cycle.
  always @(negedge CLOCK_50) begin
    if (!res_n) begin
      mc <= 0;
    end else if (mc == 0) begin
      if (tx == 1'b0) mc <= 1;
    end else begin
      if (mc >= 6 && mc <= 34 && (mc % 4) == 2) msh <= {tx, msh[7:1]};
      if (mc == 38) begin
        if (tx == 1'b1) rx_q.push_back(msh);
        else            ferr <= ferr + 1;
        mc <= 0;
      end else begin
        mc <= mc + 1;
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One bus access; returns dbi/sel sampled during the strobe cycle, ends one negedge after it.
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic r,
                           output logic [7:0] rdata, output logic rsel);
    @(negedge CLOCK_50);
    ab = a; dbo = d; rw = r; phi = 1'b1;
    @(negedge CLOCK_50);
    phi = 1'b0;
    rdata = dbi;
    rsel  = sel;
    @(negedge CLOCK_50);
    ab = 16'h0000; rw = 1'b1;
  endtask

  // Cycle-exact frame check from frame cycle 'skip' to 39, starting at the current negedge.
  task automatic check_frame(input logic [7:0] b, input string tag, input int skip);
    logic e;
    for (int c = skip; c < 40; c++) begin
      if (c < 4)       e = 1'b0;
      else if (c < 36) e = b[(c - 4) / 4];
      else             e = 1'b1;
      chk1(tag, tx, e);
      if (c != 39) @(negedge CLOCK_50);
    end
  endtask

  task automatic chk_rx(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] v;
    v = (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
    chk8(tag, v, exp);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs;
    int         to;
    logic       saw_low;
    logic [7:0] ovr_exp [5];

    res_n = 1'b0; phi = 1'b0; ab = 16'h0000; dbo = 8'h00; rw = 1'b1;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    res_n = 1'b1;
    bus_cycle(16'hD001, 8'h00, 1'b1, rd, rs);
    chk8("rst_status", rd, 8'h04);
    chk1("rst_status_sel", rs, 1'b1);

    // Single byte, cycle exact
    bus_cycle(16'hD000, 8'hA5, 1'b0, rd, rs);
    chk1("a5_sel", rs, 1'b1);
    chk1("a5_tx_before_start", tx, 1'b1);
    chk1("a5_busy_queued", busy, 1'b1);
    @(negedge CLOCK_50);
    check_frame(8'hA5, "a5_frame", 0);
    chk1("a5_busy_in_stop", busy, 1'b1);
    @(negedge CLOCK_50);
    chk1("a5_busy_idle", busy, 1'b0);
    chk1("a5_tx_idle", tx, 1'b1);
    chk32("a5_rx_count", rx_q.size(), 1);
    chk_rx("a5_rx_byte", 0, 8'hA5);
    rx_q.delete();

    // Overrun: fill while the first frame is on the line
    bus_cycle(16'hD000, 8'h11, 1'b0, rd, rs);
    for (int i = 1; i <= 5; i++) bus_cycle(16'hD000, 8'(i), 1'b0, rd, rs);
    bus_cycle(16'hD001, 8'h00, 1'b1, rd, rs);
    chk8("ovr_status_first", rd, 8'h83);
    bus_cycle(16'hD001, 8'h00, 1'b1, rd, rs);
    chk8("ovr_status_cleared", rd, 8'h03);
    to = 0;
    while (busy && to < 1000) begin
      @(negedge CLOCK_50);
      to++;
    end
    chk1("ovr_drain_timeout", busy, 1'b0);
    repeat (2) @(negedge CLOCK_50);
    ovr_exp[0] = 8'h11; ovr_exp[1] = 8'h01; ovr_exp[2] = 8'h02;
    ovr_exp[3] = 8'h03; ovr_exp[4] = 8'h04;
    chk32("ovr_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk_rx("ovr_rx_byte", i, ovr_exp[i]);
    bus_cycle(16'hD001, 8'h00, 1'b1, rd, rs);
    chk8("ovr_status_drained", rd, 8'h04);
    rx_q.delete();

    // Back-to-back frames, one idle cycle between them
    bus_cycle(16'hD000, 8'h00, 1'b0, rd, rs);
    bus_cycle(16'hD000, 8'hFF, 1'b0, rd, rs);
    check_frame(8'h00, "b2b_frame0", 2);
    @(negedge CLOCK_50);
    chk1("b2b_gap_tx", tx, 1'b1);
    chk1("b2b_gap_busy", busy, 1'b1);
    @(negedge CLOCK_50);
    check_frame(8'hFF, "b2b_frame1", 0);
    @(negedge CLOCK_50);
    chk1("b2b_busy_end", busy, 1'b0);
    repeat (2) @(negedge CLOCK_50);
    chk32("b2b_rx_count", rx_q.size(), 2);
    chk_rx("b2b_rx_first", 0, 8'h00);
    chk_rx("b2b_rx_second", 1, 8'hFF);
    rx_q.delete();

    // Reset in the middle of data bit 3, with a second byte queued
    bus_cycle(16'hD000, 8'hC3, 1'b0, rd, rs);
    bus_cycle(16'hD000, 8'h5A, 1'b0, rd, rs);
    repeat (15) @(negedge CLOCK_50);
    chk1("mid_bit3_low", tx, 1'b0);
    res_n = 1'b0;
    #1;
    chk1("mid_rst_tx", tx, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    repeat (2) @(negedge CLOCK_50);
    res_n = 1'b1;
    bus_cycle(16'hD001, 8'h00, 1'b1, rd, rs);
    chk8("mid_status", rd, 8'h04);
    saw_low = 1'b0;
    repeat (100) begin
      @(negedge CLOCK_50);
      if (tx == 1'b0) saw_low = 1'b1;
    end
    chk1("mid_no_frame", saw_low, 1'b0);
    chk32("mid_rx_count", rx_q.size(), 0);

    // Address decode
    bus_cycle(16'hD002, 8'h77, 1'b0, rd, rs);
    chk1("dec_d002_sel", rs, 1'b0);
    bus_cycle(16'h5000, 8'h66, 1'b0, rd, rs);
    chk1("dec_5000_sel", rs, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    chk1("dec_no_push_busy", busy, 1'b0);
    chk1("dec_no_push_tx", tx, 1'b1);
    bus_cycle(16'hD000, 8'h00, 1'b1, rd, rs);
    chk1("dec_rd_txdata_sel", rs, 1'b1);
    chk8("dec_rd_txdata_dbi", rd, 8'h00);
    bus_cycle(16'hD002, 8'h00, 1'b1, rd, rs);
    chk1("dec_rd_d002_sel", rs, 1'b0);
    chk8("dec_rd_d002_dbi", rd, 8'h00);
    bus_cycle(16'hD001, 8'hFF, 1'b0, rd, rs);
    chk1("dec_wr_status_sel", rs, 1'b1);
    bus_cycle(16'hD001, 8'h00, 1'b1, rd, rs);
    chk8("dec_status_unchanged", rd, 8'h04);
    repeat (45) @(negedge CLOCK_50);
    chk32("dec_rx_count", rx_q.size(), 0);
    chk32("framing_errors", ferr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
